// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the instruction/data memory-port arbiter.
package mem_req_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Wide enough for an outstanding count of 0..4.
  localparam int CNT_W = 3;

  // Packed width of {wr, size, wstrb, addr, wdata}.
  function automatic int req_bus_len(input int addr_w, input int data_w);
    return 1 + 2 + 4 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order record of which requester owns each accepted memory transaction.
module owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_owner,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic             head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      slots  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_owner;
        wr_ptr        <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the instruction and data requesters,
// holding the choice while the slave stalls and routing responses by owner.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [2:0]        outstanding
);

  localparam int BUS_W = req_bus_len(ADDR_W, DATA_W);

  logic             lock_valid;
  logic             lock_owner;
  logic             grant;
  logic             grant_req;
  logic             accept;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_head;
  logic             resp_valid;
  logic [BUS_W-1:0] inst_bus;
  logic [BUS_W-1:0] data_bus;

  // Data wins a fresh arbitration: it belongs to the older instruction.
  assign grant     = lock_valid ? lock_owner : (data_req ? OWNER_DATA : OWNER_INST);
  assign grant_req = (grant == OWNER_DATA) ? data_req : inst_req;

  // Full blocks issue regardless of a same-cycle data_ok, so no data_ok->req path.
  assign mem_req = grant_req & ~fifo_full & ~reset;
  assign accept  = mem_req & mem_addr_ok;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} =
         (grant == OWNER_DATA) ? data_bus : inst_bus;

  assign inst_addr_ok = accept & (grant == OWNER_INST);
  assign data_addr_ok = accept & (grant == OWNER_DATA);

  assign resp_valid   = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = resp_valid & (fifo_head == OWNER_INST);
  assign data_data_ok = resp_valid & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // A stalled request pins the grant; dropping req or an accept releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWNER_INST;
    end else begin
      lock_valid <= mem_req & ~mem_addr_ok;
      lock_owner <= grant;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_owner (grant),
    .pop        (resp_valid),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .head       (fifo_head),
    .count      (outstanding)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: inputs change just after each rising edge,
// outputs are sampled on the falling edge.
module tb_mem_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;

  int checks   = 0;
  int failures = 0;

  mem_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .outstanding  (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    nxt(); mid();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_outstanding", outstanding, 0);

    // Instruction read
    nxt(); reset = 0; idle_inputs();
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    mid();
    chk("ird_c0_addr_ok", inst_addr_ok, 1);
    chk("ird_c0_mem_addr", mem_addr, 32'h1c000000);
    chk("ird_c0_out", outstanding, 0);
    nxt(); idle_inputs(); mid();
    chk("ird_c1_out", outstanding, 1);
    chk("ird_c1_data_ok", inst_data_ok, 0);
    nxt(); mem_data_ok = 1; mem_rdata = 32'h02800000; mid();
    chk("ird_c2_data_ok", inst_data_ok, 1);
    chk("ird_c2_rdata", inst_rdata, 32'h02800000);
    chk("ird_c2_ddata_ok", data_data_ok, 0);
    chk("ird_c2_out", outstanding, 1);
    nxt(); idle_inputs(); mid();
    chk("ird_c3_out", outstanding, 0);

    // Collision: data wins first
    nxt();
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_addr = 32'h00000100; mem_addr_ok = 1;
    mid();
    chk("col_c0_mem_addr", mem_addr, 32'h00000100);
    chk("col_c0_data_addr_ok", data_addr_ok, 1);
    chk("col_c0_inst_addr_ok", inst_addr_ok, 0);
    nxt(); data_req = 0; mid();
    chk("col_c1_inst_addr_ok", inst_addr_ok, 1);
    chk("col_c1_mem_addr", mem_addr, 32'h1c000004);
    nxt(); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h11110000; mid();
    chk("col_out2", outstanding, 2);
    chk("col_r0_data_ok", data_data_ok, 1);
    chk("col_r0_inst_ok", inst_data_ok, 0);
    nxt(); mem_rdata = 32'h22220000; mid();
    chk("col_r1_inst_ok", inst_data_ok, 1);
    chk("col_r1_data_ok", data_data_ok, 0);
    nxt(); idle_inputs(); mid();
    chk("col_drained", outstanding, 0);

    // Lock: slave stalls inst for 3 cycles while data arrives
    nxt(); inst_req = 1; inst_addr = 32'h1c000040; mid();
    chk("lck_c0_mem_addr", mem_addr, 32'h1c000040);
    chk("lck_c0_mem_req", mem_req, 1);
    chk("lck_c0_inst_addr_ok", inst_addr_ok, 0);
    nxt(); data_req = 1; data_addr = 32'h00000200; mid();
    chk("lck_c1_mem_addr", mem_addr, 32'h1c000040);
    chk("lck_c1_data_addr_ok", data_addr_ok, 0);
    nxt(); mid();
    chk("lck_c2_mem_addr", mem_addr, 32'h1c000040);
    nxt(); mem_addr_ok = 1; mid();
    chk("lck_c3_mem_addr", mem_addr, 32'h1c000040);
    chk("lck_c3_inst_addr_ok", inst_addr_ok, 1);
    chk("lck_c3_data_addr_ok", data_addr_ok, 0);
    nxt(); inst_req = 0; mid();
    chk("lck_c4_mem_addr", mem_addr, 32'h00000200);
    chk("lck_c4_data_addr_ok", data_addr_ok, 1);
    nxt(); idle_inputs(); mem_data_ok = 1; mid();
    chk("lck_out2", outstanding, 2);
    chk("lck_r0_inst_ok", inst_data_ok, 1);
    nxt(); mid();
    chk("lck_r1_data_ok", data_data_ok, 1);
    nxt(); idle_inputs(); mid();
    chk("lck_drained", outstanding, 0);

    // Full at two outstanding; issue resumes the cycle after a pop
    nxt(); data_req = 1; data_addr = 32'h00000300; mem_addr_ok = 1; mid();
    chk("full_c0_addr_ok", data_addr_ok, 1);
    nxt(); data_addr = 32'h00000304; mid();
    chk("full_c1_addr_ok", data_addr_ok, 1);
    nxt(); data_addr = 32'h00000308; mid();
    chk("full_c2_mem_req", mem_req, 0);
    chk("full_c2_addr_ok", data_addr_ok, 0);
    chk("full_c2_out", outstanding, 2);
    nxt(); mem_data_ok = 1; mid();
    chk("full_cN_mem_req", mem_req, 0);
    chk("full_cN_data_ok", data_data_ok, 1);
    nxt(); mem_data_ok = 0; mid();
    chk("full_cN1_mem_req", mem_req, 1);
    chk("full_cN1_addr_ok", data_addr_ok, 1);
    chk("full_cN1_out", outstanding, 1);
    nxt(); idle_inputs(); mem_data_ok = 1; mid();
    chk("full_out2", outstanding, 2);
    nxt(); mid();
    nxt(); idle_inputs(); mid();
    chk("full_drained", outstanding, 0);

    // Routing: inst then data back-to-back
    nxt(); inst_req = 1; inst_addr = 32'h1c000080; mem_addr_ok = 1; mid();
    chk("rte_inst_addr_ok", inst_addr_ok, 1);
    nxt(); inst_req = 0; data_req = 1; data_addr = 32'h00000400; mid();
    chk("rte_data_addr_ok", data_addr_ok, 1);
    nxt(); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'hAAAA0000; mid();
    chk("rte_r0_inst_ok", inst_data_ok, 1);
    chk("rte_r0_data_ok", data_data_ok, 0);
    chk("rte_r0_inst_rdata", inst_rdata, 32'hAAAA0000);
    nxt(); mem_rdata = 32'h5555FFFF; mid();
    chk("rte_r1_inst_ok", inst_data_ok, 0);
    chk("rte_r1_data_ok", data_data_ok, 1);
    chk("rte_r1_data_rdata", data_rdata, 32'h5555FFFF);
    nxt(); idle_inputs(); mid();
    chk("rte_idle_inst_ok", inst_data_ok, 0);
    chk("rte_idle_data_ok", data_data_ok, 0);
    chk("rte_drained", outstanding, 0);

    // data_ok with empty FIFO is ignored
    nxt(); mem_data_ok = 1; mid();
    chk("emp_inst_ok", inst_data_ok, 0);
    chk("emp_data_ok", data_data_ok, 0);
    nxt(); mem_data_ok = 0; mid();
    chk("emp_out", outstanding, 0);

    // Reset mid-flight, then stale response
    nxt(); inst_req = 1; inst_addr = 32'h1c0000c0; mem_addr_ok = 1; mid();
    chk("rmf_accept", inst_addr_ok, 1);
    nxt(); idle_inputs(); reset = 1; mid();
    chk("rmf_rst_inst_ok", inst_data_ok, 0);
    nxt(); reset = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF; mid();
    chk("rmf_out0", outstanding, 0);
    chk("rmf_stale_inst_ok", inst_data_ok, 0);
    chk("rmf_stale_data_ok", data_data_ok, 0);
    nxt(); mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000100; mem_addr_ok = 1; mid();
    chk("rmf_next_addr_ok", inst_addr_ok, 1);
    chk("rmf_next_mem_addr", mem_addr, 32'h1c000100);
    nxt(); idle_inputs(); mid();
    chk("rmf_next_out", outstanding, 1);
    nxt(); mem_data_ok = 1; mid();
    chk("rmf_next_inst_ok", inst_data_ok, 1);
    nxt(); idle_inputs(); mid();
    chk("rmf_drained", outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
